jtopll_mmr_q: RTL and testbench

- Parametrised successor to the OPLL register front end.
- CPU writes go into a DEPTH-entry FIFO, decoupled from the operator clock.
- The FIFO drains one entry at a time; each entry's update strobe is held for exactly one full slot sweep (3*CH cenop pulses), so the register bank sees every write regardless of slot pointer phase.
- Supports CH channels (up to 16 via the low address nibble). Exposes busy/full status to the CPU side.

---
 rtl/jtopll_mmr_q.sv | 189 ++++++++++++++++++
 tb/tb_jtopll_mmr_q.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtopll_mmr_q.sv
// Queued OPLL register front end: CPU writes are buffered in a FIFO and replayed
// with strobes held for one full slot sweep. Optional sticky overflow flag: JTOPLL_MMR_OVF_EN.
module jtopll_mmr_q #(
  parameter int CH    = 9,
  parameter int GW    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cenop,
  input  logic [7:0]    din,
  input  logic          write,
  input  logic          addr,
  output logic          busy,
  output logic          full,
  output logic          ovf,
  output logic [7:0]    dout,
  output logic [GW-1:0] sel_group,
  output logic [2:0]    sel_sub,
  output logic          up_original,
  output logic          up_fnumlo,
  output logic          up_fnumhi,
  output logic          up_inst,
  output logic          rhy_en,
  output logic [4:0]    rhy_kon,
  output logic          am_dep,
  output logic          vib_dep
);

  localparam int HOLD_N = 3 * CH;
  localparam int HW     = $clog2(HOLD_N + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_reg;
  logic [7:0]      selreg_reg;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [HW-1:0]   hold_cnt_reg;

  logic            empty;
  logic            pop;
  logic            data_wr;
  logic            push;
  logic [15:0]     head;
  logic [7:0]      head_reg;
  logic [7:0]      head_data;
  logic [3:0]      ch;
  logic            ch_ok;
  logic            is_orig;
  logic            is_fnumlo;
  logic            is_fnumhi;
  logic            is_inst;
  logic            is_glob;
  logic [1:0]      ch_mod;
  logic [GW-1:0]   ch_div;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign busy    = !empty || (state_reg == HOLD);
  assign pop     = (state_reg == IDLE) && cenop && !empty;
  assign data_wr = write && addr;
  // A full FIFO still accepts a push when the head leaves on the same clk.
  assign push    = data_wr && (!full || pop);

  assign head      = mem[rd_ptr_reg];
  assign head_reg  = head[15:8];
  assign head_data = head[7:0];

  assign ch        = head_reg[3:0];
  assign ch_ok     = ({28'd0, ch} < 32'(CH));
  assign is_orig   = (head_reg[7:3] == 5'd0);
  assign is_fnumlo = (head_reg[7:4] == 4'h1) && ch_ok;
  assign is_fnumhi = (head_reg[7:4] == 4'h2) && ch_ok;
  assign is_inst   = (head_reg[7:4] == 4'h3) && ch_ok;
  assign is_glob   = (head_reg == 8'h0E);
  assign ch_mod    = 2'(ch % 4'd3);
  assign ch_div    = GW'(ch / 4'd3);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {selreg_reg, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      selreg_reg  <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      if (write && !addr) begin
        selreg_reg <= din;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      dout         <= '0;
      sel_group    <= '0;
      sel_sub      <= '0;
      up_original  <= 1'b0;
      up_fnumlo    <= 1'b0;
      up_fnumhi    <= 1'b0;
      up_inst      <= 1'b0;
      rhy_en       <= 1'b0;
      rhy_kon      <= '0;
      am_dep       <= 1'b0;
      vib_dep      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          hold_cnt_reg <= '0;
          if (pop) begin
            dout <= head_data;
            if (is_orig) begin
              up_original <= 1'b1;
              sel_sub     <= head_reg[2:0];
              state_reg   <= HOLD;
            end else if (is_fnumlo || is_fnumhi || is_inst) begin
              up_fnumlo <= is_fnumlo;
              up_fnumhi <= is_fnumhi;
              up_inst   <= is_inst;
              sel_group <= ch_div;
              sel_sub   <= {1'b0, ch_mod};
              state_reg <= HOLD;
            end else if (is_glob) begin
              // Globals are applied at pop time so they stay ordered with channel writes.
              am_dep  <= head_data[7];
              vib_dep <= head_data[6];
              rhy_en  <= head_data[5];
              rhy_kon <= head_data[4:0];
            end
          end
        end
        HOLD: begin
          if (cenop) begin
            if (hold_cnt_reg == HW'(HOLD_N - 1)) begin
              hold_cnt_reg <= '0;
              up_original  <= 1'b0;
              up_fnumlo    <= 1'b0;
              up_fnumhi    <= 1'b0;
              up_inst      <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + HW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef JTOPLL_MMR_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (data_wr && !push) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jtopll_mmr_q.sv
// Directed bench for jtopll_mmr_q: default CH=9 instance plus a CH=12 instance
// driven by the same CPU/operator stimulus.
module tb_jtopll_mmr_q;

`ifdef JTOPLL_MMR_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cenop = 1'b0;
  logic [7:0] din = 8'h00;
  logic       write = 1'b0;
  logic       addr = 1'b0;

  logic       busy, full, ovf;
  logic [7:0] dout;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_original, up_fnumlo, up_fnumhi, up_inst;
  logic       rhy_en, am_dep, vib_dep;
  logic [4:0] rhy_kon;

  logic       busy12, full12, ovf12;
  logic [7:0] dout12;
  logic [1:0] sel_group12;
  logic [2:0] sel_sub12;
  logic       up_original12, up_fnumlo12, up_fnumhi12, up_inst12;
  logic       rhy_en12, am_dep12, vib_dep12;
  logic [4:0] rhy_kon12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtopll_mmr_q u_dut (
    .clk(clk), .rst(rst), .cenop(cenop), .din(din), .write(write), .addr(addr),
    .busy(busy), .full(full), .ovf(ovf), .dout(dout),
    .sel_group(sel_group), .sel_sub(sel_sub),
    .up_original(up_original), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
    .rhy_en(rhy_en), .rhy_kon(rhy_kon), .am_dep(am_dep), .vib_dep(vib_dep)
  );

  jtopll_mmr_q #(.CH(12), .GW(2), .DEPTH(4), .AW(2)) u_dut12 (
    .clk(clk), .rst(rst), .cenop(cenop), .din(din), .write(write), .addr(addr),
    .busy(busy12), .full(full12), .ovf(ovf12), .dout(dout12),
    .sel_group(sel_group12), .sel_sub(sel_sub12),
    .up_original(up_original12), .up_fnumlo(up_fnumlo12), .up_fnumhi(up_fnumhi12), .up_inst(up_inst12),
    .rhy_en(rhy_en12), .rhy_kon(rhy_kon12), .am_dep(am_dep12), .vib_dep(vib_dep12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    write = 1'b1;
    addr  = a;
    din   = d;
    tick();
    write = 1'b0;
    addr  = 1'b0;
  endtask

  // n cenop pulses, each followed by one idle clk
  task automatic cen(input int n);
    repeat (n) begin
      cenop = 1'b1;
      tick();
      cenop = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_dout", dout, 0);
    check("rst_strobes", {up_original, up_fnumlo, up_fnumhi, up_inst}, 0);
    check("rst_globals", {am_dep, vib_dep, rhy_en, rhy_kon}, 0);
    check("rst_ovf", ovf, 0);

    // Channel write to fnum high, channel 3
    wr(0, 8'h23);
    wr(1, 8'h15);
    check("ch_busy_queued", busy, 1);
    check("ch_no_strobe_yet", up_fnumhi, 0);
    cen(1);
    check("ch_up_fnumhi", up_fnumhi, 1);
    check("ch_sel_group", sel_group, 1);
    check("ch_sel_sub", sel_sub, 0);
    check("ch_dout", dout, 8'h15);
    cen(26);
    check("ch_hold_26", up_fnumhi, 1);
    check("ch_busy_26", busy, 1);
    cen(1);
    check("ch_hold_27", up_fnumhi, 0);
    check("ch_busy_end", busy, 0);

    // Custom instrument register keeps the previous group
    wr(0, 8'h05);
    wr(1, 8'hC3);
    cen(1);
    check("orig_strobe", up_original, 1);
    check("orig_sub", sel_sub, 5);
    check("orig_group_kept", sel_group, 1);
    cen(27);
    check("orig_end", up_original, 0);

    // Ordering: fnumlo, global, inst
    wr(0, 8'h10); wr(1, 8'hAA);
    wr(0, 8'h0E); wr(1, 8'h3F);
    wr(0, 8'h31); wr(1, 8'h07);
    cen(1);
    check("ord_fnumlo", up_fnumlo, 1);
    check("ord_fnumlo_dout", dout, 8'hAA);
    check("ord_fnumlo_group", sel_group, 0);
    cen(27);
    check("ord_fnumlo_end", up_fnumlo, 0);
    check("ord_rhy_before", rhy_en, 0);
    cen(1);
    check("ord_glob_strobes", {up_original, up_fnumlo, up_fnumhi, up_inst}, 0);
    check("ord_glob_vals", {am_dep, vib_dep, rhy_en, rhy_kon}, 8'h3F);
    check("ord_glob_dout", dout, 8'h3F);
    check("ord_glob_busy", busy, 1);
    cen(1);
    check("ord_inst", up_inst, 1);
    check("ord_inst_sub", sel_sub, 1);
    check("ord_inst_dout", dout, 8'h07);
    cen(27);
    check("ord_inst_end", up_inst, 0);
    check("ord_busy_end", busy, 0);

    // Full / overflow
    do_reset();
    wr(0, 8'h10);
    for (int i = 1; i <= 5; i++) begin
      wr(1, 8'(i));
      if (i == 3) check("full_after3", full, 0);
      if (i >= 4) check($sformatf("full_after%0d", i), full, 1);
    end
    check("ovf_flag", ovf, OVF_EXP);
    cenop = 1'b1; write = 1'b1; addr = 1'b1; din = 8'h99;
    tick();
    cenop = 1'b0; write = 1'b0; addr = 1'b0;
    check("pushpop_full", full, 1);
    check("pushpop_dout", dout, 8'h01);
    check("pushpop_strobe", up_fnumlo, 1);
    cen(27);
    cen(1); check("drain_2", dout, 8'h02); cen(27);
    cen(1); check("drain_3", dout, 8'h03); cen(27);
    cen(1); check("drain_4", dout, 8'h04); cen(27);
    cen(1); check("drain_99", dout, 8'h99); cen(27);
    check("drain_busy", busy, 0);
    check("drain_full", full, 0);
    check("ovf_sticky", ovf, OVF_EXP);

    // Reset during hold with two entries queued
    wr(0, 8'h20);
    wr(1, 8'h11); wr(1, 8'h22); wr(1, 8'h33);
    cen(1);
    check("rh_strobe", up_fnumhi, 1);
    check("rh_busy", busy, 1);
    cen(5);
    rst = 1'b1;
    tick();
    check("rh_busy_rst", busy, 0);
    check("rh_full_rst", full, 0);
    check("rh_strobes_rst", {up_original, up_fnumlo, up_fnumhi, up_inst}, 0);
    check("rh_dout_rst", dout, 0);
    check("rh_misc_rst", {sel_group, sel_sub, ovf, am_dep, vib_dep, rhy_en, rhy_kon}, 0);
    rst = 1'b0;
    cen(30);
    check("rh_no_strobe", up_fnumhi, 0);
    check("rh_busy_after", busy, 0);
    check("rh_dout_after", dout, 0);

    // Invalid channel for CH=9
    wr(0, 8'h19);
    wr(1, 8'h55);
    cenop = 1'b1;
    tick();
    cenop = 1'b0;
    check("inv_strobes", {up_original, up_fnumlo, up_fnumhi, up_inst}, 0);
    check("inv_busy", busy, 0);
    check("inv_dout", dout, 8'h55);

    // Parametric CH=12: channel 11 valid there, invalid for CH=9
    do_reset();
    wr(0, 8'h3B);
    wr(1, 8'h66);
    cen(1);
    check("p12_up_inst", up_inst12, 1);
    check("p12_group", sel_group12, 3);
    check("p12_sub", sel_sub12, 2);
    check("p12_dout", dout12, 8'h66);
    check("p9_ignored", up_inst, 0);
    check("p9_busy", busy, 0);
    cen(35);
    check("p12_hold_35", up_inst12, 1);
    cen(1);
    check("p12_hold_36", up_inst12, 0);
    check("p12_busy_end", busy12, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
